// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter.
//   MODE_WRAP / MODE_SAT : values of the MODE parameter
//   default_max()        : largest value representable in a given width,
//                          used as the default top count
package counter_pkg;

    localparam int MODE_WRAP = 0;   // wrap modulo MAX_VAL+1
    localparam int MODE_SAT  = 1;   // saturate at 0 / MAX_VAL

    // All-ones value for a WIDTH-bit counter. Valid for widths below 32.
    function automatic int default_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/cnt_step_calc.sv
// Combinational next-value calculator for param_updown_counter.
// Ports:
//   q        in   WIDTH   current count
//   step     in   STEP_W  amount to add / subtract
//   up_down  in   1       1 = up, 0 = down
//   mode     in   1       0 = wrap, 1 = saturate
//   q_next   out  WIDTH   value to register when counting is enabled
//   boundary out  1       count crossed MAX_VAL (up) or went below 0 (down)
module cnt_step_calc #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255,
    parameter int STEP_W  = 4
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [STEP_W-1:0] step,
    input  logic              up_down,
    input  logic              mode,
    output logic [WIDTH-1:0]  q_next,
    output logic              boundary
);

    // All arithmetic is carried one bit wider than the count so that
    // q + step and q + modulus never overflow.
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] MOD_EXT = MAX_EXT + (WIDTH+1)'(1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] step_mod;
    logic [WIDTH:0] sum_raw;
    logic [WIDTH:0] sum_mod;
    logic [WIDTH:0] wrap_up;
    logic [WIDTH:0] wrap_dn;
    logic [WIDTH:0] sat_up;
    logic [WIDTH:0] sat_dn;
    logic [WIDTH:0] next_ext;
    logic           unused_msb;

    assign q_ext    = {1'b0, q};
    assign step_ext = (WIDTH+1)'(step);

    // In wrap mode a step larger than the modulus only contributes its
    // remainder; a full extra lap lands back on the same value.
    assign step_mod = step_ext % MOD_EXT;

    assign sum_raw  = q_ext + step_ext;
    assign sum_mod  = q_ext + step_mod;

    // Boundary is judged on the raw step: any step that carries the count
    // past the top (or below zero) is an event, even if the wrapped result
    // happens to equal the starting value.
    assign boundary = up_down ? (sum_raw > MAX_EXT) : (step_ext > q_ext);

    assign wrap_up  = (sum_mod > MAX_EXT) ? (sum_mod - MOD_EXT) : sum_mod;
    assign wrap_dn  = (step_mod <= q_ext) ? (q_ext - step_mod)
                                          : (q_ext + MOD_EXT - step_mod);
    assign sat_up   = boundary ? MAX_EXT : sum_raw;
    assign sat_dn   = boundary ? '0      : (q_ext - step_ext);

    always_comb begin
        next_ext = q_ext;
        if (mode) begin
            next_ext = up_down ? sat_up : sat_dn;
        end else begin
            next_ext = up_down ? wrap_up : wrap_dn;
        end
    end

    // Every selected result is <= MAX_VAL, so the top bit is always zero.
    assign q_next     = next_ext[WIDTH-1:0];
    assign unused_msb = next_ext[WIDTH];

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with wrap or saturate behaviour.
// Ports:
//   clk       in   1       clock, rising edge
//   rst       in   1       asynchronous reset, active-high
//   clear     in   1       synchronous clear (highest priority)
//   load      in   1       synchronous load of d (clamped to MAX_VAL)
//   d         in   WIDTH   load value
//   en        in   1       count enable (lowest priority)
//   up_down   in   1       1 = count up, 0 = count down
//   step      in   STEP_W  amount per enabled cycle
//   q         out  WIDTH   registered count
//   tc        out  1       one-cycle pulse on a boundary crossing
//   ovf       out  1       sticky over/underflow flag
//   load_err  out  1       one-cycle pulse when a load was clamped
//   at_zero   out  1       q == 0
//   at_max    out  1       q == MAX_VAL
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = default_max(WIDTH),
    parameter int STEP_W  = 4,
    parameter int MODE    = MODE_WRAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  d,
    input  logic              en,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  q,
    output logic              tc,
    output logic              ovf,
    output logic              load_err,
    output logic              at_zero,
    output logic              at_max
);

    localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MAX_VAL);
    localparam logic             MODE_BIT = (MODE == MODE_SAT);

    logic [WIDTH-1:0] q_reg,        q_next;
    logic             tc_reg,       tc_next;
    logic             ovf_reg,      ovf_next;
    logic             load_err_reg, load_err_next;

    logic [WIDTH-1:0] calc_q;
    logic             calc_boundary;

    cnt_step_calc #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W)
    ) u_step_calc (
        .q        (q_reg),
        .step     (step),
        .up_down  (up_down),
        .mode     (MODE_BIT),
        .q_next   (calc_q),
        .boundary (calc_boundary)
    );

    // clear > load > en. Pulses (tc, load_err) default low so they only
    // last the single cycle in which they are triggered.
    always_comb begin
        q_next        = q_reg;
        ovf_next      = ovf_reg;
        tc_next       = 1'b0;
        load_err_next = 1'b0;
        if (clear) begin
            q_next   = '0;
            ovf_next = 1'b0;
        end else if (load) begin
            if (d > MAX_Q) begin
                q_next        = MAX_Q;
                load_err_next = 1'b1;
            end else begin
                q_next = d;
            end
        end else if (en) begin
            q_next  = calc_q;
            tc_next = calc_boundary;
            if (calc_boundary) begin
                ovf_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg        <= '0;
            tc_reg       <= 1'b0;
            ovf_reg      <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            q_reg        <= q_next;
            tc_reg       <= tc_next;
            ovf_reg      <= ovf_next;
            load_err_reg <= load_err_next;
        end
    end

    assign q        = q_reg;
    assign tc       = tc_reg;
    assign ovf      = ovf_reg;
    assign load_err = load_err_reg;
    assign at_zero  = (q_reg == '0);
    assign at_max   = (q_reg == MAX_Q);

endmodule
